cbd_poly_writer: RTL and testbench

Downstream stage of the CBD noise sampler in the Kyber768 encryption path. Captures one 4096-bit polynomial of signed 16-bit coefficients in [-2,2] and maps each coefficient into [0, q-1] with q = 3329. Streams the result as 12-bit pairs over a valid/ready write port into the noise-polynomial RAM. The RAM holds e1[0..2], e2 and r[0..2] in seven 128-word slots.

---
 rtl/kyber_pkg.sv | 28 ++
 rtl/coeff_modq_map.sv | 31 +++
 rtl/cbd_poly_writer.sv | 163 ++++++++++++++++
 tb/tb_cbd_poly_writer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kyber_pkg
//  Purpose  : Shared Kyber constants and the noise-polynomial RAM slot map.
//  Contents : KYBER_N, KYBER_Q, ETA2, COEFF_W, OUT_W, noise_slot_e
//  Revision : 1.0 - initial release
// ============================================================================
package kyber_pkg;

  localparam int KYBER_N = 256;   // coefficients per polynomial
  localparam int KYBER_Q = 3329;  // modulus
  localparam int ETA2    = 2;     // CBD magnitude bound for e1/e2/r
  localparam int COEFF_W = 16;    // signed sampler coefficient width
  localparam int OUT_W   = 12;    // reduced coefficient width

  // Seven 128-word slots in the noise-polynomial RAM; code 7 is unused.
  typedef enum logic [2:0] {
    E1_0 = 3'd0,
    E1_1 = 3'd1,
    E1_2 = 3'd2,
    E2   = 3'd3,
    R_0  = 3'd4,
    R_1  = 3'd5,
    R_2  = 3'd6
  } noise_slot_e;

endpackage
`default_nettype wire

// File: rtl/coeff_modq_map.sv
`default_nettype none
// ============================================================================
//  Module   : coeff_modq_map
//  Purpose  : Maps one signed CBD coefficient into [0, Q-1] and flags
//             magnitudes above ETA.
//  Ports    : coeff  - signed COEFF_W-bit input coefficient
//             mapped - OUT_W-bit result (c < 0 ? c + Q : c, truncated)
//             oor    - high when coeff > ETA or coeff < -ETA
//  Revision : 1.0 - initial release
// ============================================================================
module coeff_modq_map #(
  parameter int COEFF_W = 16,
  parameter int OUT_W   = 12,
  parameter int Q       = 3329,
  parameter int ETA     = 2
) (
  input  logic signed [COEFF_W-1:0] coeff,
  output logic        [OUT_W-1:0]   mapped,
  output logic                      oor
);

  // Adding Q modulo 2^OUT_W only needs the low OUT_W bits of both operands,
  // which gives the truncated c + Q without a wider adder.
  localparam logic        [OUT_W-1:0]   c_Q_LO = OUT_W'(Q);
  localparam logic signed [COEFF_W-1:0] c_ETA  = COEFF_W'(ETA);

  assign mapped = coeff[COEFF_W-1] ? (coeff[OUT_W-1:0] + c_Q_LO) : coeff[OUT_W-1:0];
  assign oor    = (coeff > c_ETA) || (coeff < -c_ETA);

endmodule
`default_nettype wire

// File: rtl/cbd_poly_writer.sv
`default_nettype none
// ============================================================================
//  Module   : cbd_poly_writer
//  Purpose  : Captures a full CBD noise polynomial into a shadow register and
//             streams it, reduced mod Q, as LANES-wide beats into one slot of
//             the noise-polynomial RAM over a valid/ready port.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             start           - one-cycle request, captures poly_in and slot
//             poly_in         - N signed coefficients, coeff i at [i*COEFF_W +: COEFF_W]
//             slot            - destination slot 0..6
//             busy / done     - streaming in progress / one-cycle completion
//             range_err       - sticky: bad coefficient emitted or slot 7 requested
//             wr_valid/ready  - write handshake
//             wr_addr/wr_data - {slot, beat} and packed mapped lanes
//  Revision : 1.0 - initial release
// ============================================================================
module cbd_poly_writer
  import kyber_pkg::*;
#(
  parameter int N       = kyber_pkg::KYBER_N,
  parameter int COEFF_W = kyber_pkg::COEFF_W,
  parameter int OUT_W   = kyber_pkg::OUT_W,
  parameter int Q       = kyber_pkg::KYBER_Q,
  parameter int ETA     = kyber_pkg::ETA2,
  parameter int LANES   = 2,
  parameter int SLOT_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N*COEFF_W-1:0]        poly_in,
  input  logic [SLOT_W-1:0]           slot,
  output logic                        busy,
  output logic                        done,
  output logic                        range_err,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [SLOT_W+$clog2(N/LANES)-1:0] wr_addr,
  output logic [LANES*OUT_W-1:0]      wr_data
);

  localparam int c_BEATS  = N / LANES;
  localparam int c_BEAT_W = $clog2(c_BEATS);
  localparam int c_PAIR_W = LANES * COEFF_W;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e              r_state;
  logic [c_BEAT_W-1:0] r_beat;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_busy;
  logic                r_done;
  logic                r_wr_valid;
  logic                r_range_err;

  // Shadow copy of the polynomial, organised one word per beat so the
  // beat counter indexes it directly.
  logic [c_PAIR_W-1:0] r_shadow [c_BEATS];

  logic                   w_slot_ok;
  logic                   w_capture;
  logic                   w_accept;
  logic [c_PAIR_W-1:0]    w_pair;
  logic [LANES*OUT_W-1:0] w_data;
  logic [LANES-1:0]       w_oor;

  assign w_slot_ok = (slot <= SLOT_W'(R_2));
  assign w_capture = start && (r_state == S_IDLE) && w_slot_ok;
  assign w_accept  = r_wr_valid && wr_ready;
  assign w_pair    = r_shadow[r_beat];

  // Datapath storage only; its contents never reach the outputs unless
  // wr_valid is high, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int b = 0; b < c_BEATS; b++) begin
        r_shadow[b] <= poly_in[b*c_PAIR_W +: c_PAIR_W];
      end
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      coeff_modq_map #(
        .COEFF_W (COEFF_W),
        .OUT_W   (OUT_W),
        .Q       (Q),
        .ETA     (ETA)
      ) u_map (
        .coeff  (w_pair[l*COEFF_W +: COEFF_W]),
        .mapped (w_data[l*OUT_W +: OUT_W]),
        .oor    (w_oor[l])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_slot      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_slot_ok) begin
              r_state     <= S_STREAM;
              r_slot      <= slot;
              r_beat      <= '0;
              r_busy      <= 1'b1;
              r_wr_valid  <= 1'b1;
              r_range_err <= 1'b0;
            end else begin
              // Slot 7 does not exist: flag it and stay idle.
              r_range_err <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            if (|w_oor) begin
              r_range_err <= 1'b1;
            end
            if (r_beat == c_LAST_BEAT) begin
              r_state    <= S_DONE;
              r_wr_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign range_err = r_range_err;
  assign wr_valid  = r_wr_valid;
  // Address and data read as zero whenever no beat is offered.
  assign wr_addr   = r_wr_valid ? {r_slot, r_beat} : '0;
  assign wr_data   = r_wr_valid ? w_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_cbd_poly_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbd_poly_writer
//  Purpose  : Directed self-checking bench for cbd_poly_writer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cbd_poly_writer;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4095:0] poly_in;
  logic [2:0]    slot;
  logic          busy;
  logic          done;
  logic          range_err;
  logic          wr_valid;
  logic          wr_ready;
  logic [9:0]    wr_addr;
  logic [23:0]   wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by run_stream.
  logic [9:0]  got_addr [128];
  logic [23:0] got_data [128];
  int n_beats, n_done, done_cycle, first_err_n, stall_bad, busy_bad;
  int first_valid_cycle, busy_seen;

  cbd_poly_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .poly_in   (poly_in),
    .slot      (slot),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_map(input logic signed [15:0] c);
    int v;
    v = c;
    if (v < 0) v = v + 3329;
    return v[11:0];
  endfunction

  function automatic logic [23:0] ref_beat(input logic [4095:0] p, input int k);
    return {ref_map(p[(2*k+1)*16 +: 16]), ref_map(p[(2*k)*16 +: 16])};
  endfunction

  function automatic logic [4095:0] cyc_poly();
    logic [4095:0] p;
    logic signed [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'(i % 5) - 16'sd2;
      p[i*16 +: 16] = v;
    end
    return p;
  endfunction

  // Issues start, then services the write port for up to budget cycles,
  // stopping (at the DONE cycle, 1 ns after its edge) once done is seen.
  task automatic run_stream(input logic [4095:0] p, input logic [2:0] s,
                            input int pct, input int budget);
    logic stalled;
    logic [9:0]  ha;
    logic [23:0] hd;
    n_beats = 0; n_done = 0; done_cycle = -1; first_err_n = -1;
    stall_bad = 0; busy_bad = 0; first_valid_cycle = -1; busy_seen = 0;
    stalled = 1'b0; ha = '0; hd = '0;
    poly_in = p; slot = s; start = 1'b1; wr_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      wr_ready = ($urandom_range(0, 99) < pct);
      if (busy) busy_seen = 1;
      if (range_err && first_err_n < 0) first_err_n = n_beats;
      if (done) begin
        n_done++;
        done_cycle = c;
        break;
      end
      if (wr_valid) begin
        if (first_valid_cycle < 0) first_valid_cycle = c;
        if (!busy) busy_bad++;
        if (stalled && (wr_addr !== ha || wr_data !== hd)) stall_bad++;
        if (wr_ready) begin
          if (n_beats < 128) begin
            got_addr[n_beats] = wr_addr;
            got_data[n_beats] = wr_data;
          end
          n_beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          ha = wr_addr;
          hd = wr_data;
        end
      end
      @(posedge clk); #1;
    end
    wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wr_ready = 1'b0; poly_in = '0; slot = '0;
    #12;
    n_checks++;
    if ({busy, done, range_err, wr_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, range_err, wr_valid});
    end
    n_checks++;
    if (wr_addr !== 10'd0 || wr_data !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h data %h expected 0 0", wr_addr, wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_poly();
    int bad;
    run_stream('0, 3'd3, 100, 200);
    n_checks++;
    if (n_beats !== 128) begin
      n_fail++; $display("FAIL zero_beats: got %0d expected 128", n_beats);
    end
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (got_addr[k] !== 10'(10'h180 + k) || got_data[k] !== 24'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL zero_addr_data: got %0d bad beats expected 0", bad);
    end
    n_checks++;
    if (first_valid_cycle !== 0 || done_cycle !== 128) begin
      n_fail++;
      $display("FAIL zero_latency: got valid@%0d done@%0d expected 0 and 128",
               first_valid_cycle, done_cycle);
    end
    n_checks++;
    if (range_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_flags_at_done: got err %b busy %b expected 0 0", range_err, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || wr_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_done_width: got done %b valid %b expected 0 0", done, wr_valid);
    end
  endtask

  task automatic test_pattern();
    logic [4095:0] p;
    int bad;
    p = cyc_poly();
    run_stream(p, 3'd0, 100, 200);
    n_checks++;
    if (got_data[0] !== 24'hD00CFF || got_data[1] !== 24'h001000 || got_data[2] !== 24'hCFF002) begin
      n_fail++;
      $display("FAIL pattern_first_beats: got %h %h %h expected d00cff 001000 cff002",
               got_data[0], got_data[1], got_data[2]);
    end
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (got_data[k] !== ref_beat(p, k) || got_addr[k] !== 10'(k)) bad++;
    end
    n_checks++;
    if (bad !== 0 || n_beats !== 128) begin
      n_fail++; $display("FAIL pattern_golden: got %0d bad of %0d beats expected 0 of 128", bad, n_beats);
    end
    // Start coincident with done must be ignored.
    start = 1'b1; slot = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_at_done: got valid %b busy %b expected 0 0", wr_valid, busy);
    end
  endtask

  task automatic test_random_ready();
    logic [4095:0] p;
    logic signed [15:0] v;
    int bad;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom_range(0, 4)) - 16'sd2;
      p[i*16 +: 16] = v;
    end
    run_stream(p, 3'd4, 30, 3000);
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (got_addr[k] !== {3'd4, 7'(k)} || got_data[k] !== ref_beat(p, k)) bad++;
    end
    n_checks++;
    if (bad !== 0 || n_beats !== 128) begin
      n_fail++; $display("FAIL random_sequence: got %0d bad of %0d beats expected 0 of 128", bad, n_beats);
    end
    n_checks++;
    if (stall_bad !== 0 || busy_bad !== 0) begin
      n_fail++; $display("FAIL random_stall_stable: got %0d unstable %0d not-busy expected 0 0", stall_bad, busy_bad);
    end
    n_checks++;
    if (n_done !== 1) begin
      n_fail++; $display("FAIL random_done_seen: got %0d expected 1", n_done);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL random_single_done: got %b expected 0", done);
    end
  endtask

  task automatic test_range_err();
    logic [4095:0] p;
    p = '0;
    p[17*16 +: 16] = 16'sd3;
    run_stream(p, 3'd6, 100, 200);
    n_checks++;
    if (first_err_n !== 9) begin
      n_fail++; $display("FAIL range_rise: got first seen after %0d beats expected 9", first_err_n);
    end
    n_checks++;
    if (got_data[8] !== 24'h003000 || got_addr[8] !== 10'h308) begin
      n_fail++; $display("FAIL range_beat8: got addr %h data %h expected 308 003000", got_addr[8], got_data[8]);
    end
    n_checks++;
    if (n_beats !== 128 || n_done !== 1 || range_err !== 1'b1) begin
      n_fail++;
      $display("FAIL range_complete: got beats %0d done %0d err %b expected 128 1 1", n_beats, n_done, range_err);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (range_err !== 1'b1) begin
      n_fail++; $display("FAIL range_sticky: got %b expected 1", range_err);
    end
    // A new accepted start clears the flag; -2..2 coefficients keep it clear.
    run_stream(cyc_poly(), 3'd1, 100, 200);
    n_checks++;
    if (first_err_n !== -1 || range_err !== 1'b0) begin
      n_fail++; $display("FAIL range_clear: got first %0d err %b expected -1 0", first_err_n, range_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_and_reset();
    logic [4095:0] p;
    int bad, seen_bad;
    p = cyc_poly();
    poly_in = p; slot = 3'd2; start = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 40) begin
        start = 1'b1; slot = 3'd5; poly_in = '0;
      end else begin
        start = 1'b0;
      end
      if (wr_valid !== 1'b1 || wr_addr !== {3'd2, 7'(c)} || wr_data !== ref_beat(p, c)) bad++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL start_ignored: got %0d bad beats expected 0", bad);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, range_err, wr_valid} !== 4'b0000 || wr_addr !== 10'd0 || wr_data !== 24'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got flags %b addr %h data %h expected 0000 0 0",
               {busy, done, range_err, wr_valid}, wr_addr, wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen_bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (done || wr_valid || busy) seen_bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen_bad !== 0) begin
      n_fail++; $display("FAIL reset_no_done: got %0d active cycles expected 0", seen_bad);
    end
    run_stream(p, 3'd1, 100, 200);
    n_checks++;
    if (got_addr[0] !== 10'h080 || got_data[0] !== 24'hD00CFF || n_beats !== 128 || n_done !== 1) begin
      n_fail++;
      $display("FAIL restart: got addr %h data %h beats %0d done %0d expected 080 d00cff 128 1",
               got_addr[0], got_data[0], n_beats, n_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_slot7();
    run_stream(cyc_poly(), 3'd7, 100, 10);
    n_checks++;
    if (range_err !== 1'b1) begin
      n_fail++; $display("FAIL slot7_err: got %b expected 1", range_err);
    end
    n_checks++;
    if (first_valid_cycle !== -1 || n_beats !== 0 || n_done !== 0 || busy_seen !== 0) begin
      n_fail++;
      $display("FAIL slot7_abort: got valid@%0d beats %0d done %0d busy %0d expected -1 0 0 0",
               first_valid_cycle, n_beats, n_done, busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_zero_poly();
    test_pattern();
    test_random_ready();
    test_range_err();
    test_ignore_and_reset();
    test_slot7();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
